mult8_seq_ctrl: RTL and testbench

Sequencing controller that computes an unsigned 8x8 -> 16-bit product. It time-multiplexes one external 4x4 combinational multiplier core over four partial-product steps and accumulates the shifted results. The core's port names and widths are x[3:0], y[3:0] and o[7:0]. The block sits between a valid/ready requester and the core; the core is instantiated outside, so a future arbiter can share it.

---
 rtl/mult8_seq_ctrl.sv | 111 +++++++++++
 tb/tb_mult8_seq_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult8_seq_ctrl.sv
// mult8_seq_ctrl: unsigned 8x8 multiply sequenced over an external 4x4 core.
// Four nibble partial products are shifted and summed into a 16-bit accumulator.
module mult8_seq_ctrl #(
  parameter bit PIPE_PP = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_p,
  output logic        busy,
  output logic [3:0]  core_x,
  output logic [3:0]  core_y,
  input  logic [7:0]  core_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [1:0]  step;
  logic [3:0]  shamt;
  logic [15:0] acc;
  logic [15:0] pp_now;
  logic [15:0] pp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = MUL;
      MUL:     if (step == 2'd3) state_nxt = PIPE_PP ? DRAIN : DONE;
      DRAIN:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
    out_p     = out_valid ? acc : 16'h0000;
    core_x    = 4'h0;
    core_y    = 4'h0;
    shamt     = 4'd0;
    if (state == MUL) begin
      unique case (step)
        2'd0: begin core_x = a[3:0]; core_y = b[3:0]; shamt = 4'd0; end
        2'd1: begin core_x = a[3:0]; core_y = b[7:4]; shamt = 4'd4; end
        2'd2: begin core_x = a[7:4]; core_y = b[3:0]; shamt = 4'd4; end
        default: begin core_x = a[7:4]; core_y = b[7:4]; shamt = 4'd8; end
      endcase
    end
  end

  assign pp_now = {8'h00, core_o} << shamt;

  // With PIPE_PP the add consumes last cycle's partial product, so DRAIN adds the final one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a    <= 8'h00;
      b    <= 8'h00;
      step <= 2'd0;
      acc  <= 16'h0000;
      pp_q <= 16'h0000;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a    <= in_a;
            b    <= in_b;
            step <= 2'd0;
            acc  <= 16'h0000;
            pp_q <= 16'h0000;
          end
        end
        MUL: begin
          step <= step + 2'd1;
          if (PIPE_PP) begin
            acc  <= acc + pp_q;
            pp_q <= pp_now;
          end else begin
            acc <= acc + pp_now;
          end
        end
        DRAIN: begin
          acc  <= acc + pp_q;
          pp_q <= 16'h0000;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// tb_mult8_seq_ctrl: directed and random checks of both PIPE_PP variants.
// Products are compared against plain a*b from an in-order queue.
module tb_mult8_seq_ctrl;

  logic        clk;
  logic        rst_n     [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [7:0]  in_a      [2];
  logic [7:0]  in_b      [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [15:0] out_p     [2];
  logic        busy      [2];
  logic [3:0]  core_x    [2];
  logic [3:0]  core_y    [2];
  logic [7:0]  core_o    [2];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign core_o[0] = core_x[0] * core_y[0];
  assign core_o[1] = core_x[1] * core_y[1];

  mult8_seq_ctrl #(.PIPE_PP(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_p(out_p[0]), .busy(busy[0]),
    .core_x(core_x[0]), .core_y(core_y[0]), .core_o(core_o[0])
  );

  mult8_seq_ctrl #(.PIPE_PP(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_p(out_p[1]), .busy(busy[1]),
    .core_x(core_x[1]), .core_y(core_y[1]), .core_o(core_o[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] wa;
    logic [15:0] wb;
    wa = {8'h00, a};
    wb = {8'h00, b};
    return wa * wb;
  endfunction

  task automatic chk_idle(input int d, input string tag);
    chk({tag, " in_ready"}, in_ready[d], 1);
    chk({tag, " out_valid"}, out_valid[d], 0);
    chk({tag, " busy"}, busy[d], 0);
    chk({tag, " out_p"}, out_p[d], 0);
    chk({tag, " core_x"}, core_x[d], 0);
    chk({tag, " core_y"}, core_y[d], 0);
  endtask

  task automatic xact(input int d, input logic [7:0] a, input logic [7:0] b,
                      input int lat, input string tag);
    int n;
    n = 0;
    while (!in_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " ready"}, in_ready[d], 1);
    in_a[d] = a;
    in_b[d] = b;
    in_valid[d] = 1'b1;
    out_ready[d] = 1'b0;
    @(negedge clk);
    in_valid[d] = 1'b0;
    in_a[d] = 8'($urandom);
    in_b[d] = 8'($urandom);
    n = 1;
    while (!out_valid[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, n, lat);
    chk({tag, " product"}, out_p[d], prod(a, b));
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    chk({tag, " drop"}, out_valid[d], 0);
  endtask

  task automatic rand_run(input int d, input int duty);
    logic [15:0] q[$];
    logic [15:0] e;
    logic [15:0] pp;
    logic        pv;
    int nacc;
    int nout;
    int cyc;
    nacc = 0;
    nout = 0;
    cyc = 0;
    pv = 1'b0;
    pp = 16'h0000;
    while (nout < 1000 && cyc < 25000) begin
      in_valid[d]  = (nacc < 1000) && ($urandom_range(0, 99) < 60);
      in_a[d]      = 8'($urandom);
      in_b[d]      = 8'($urandom);
      out_ready[d] = ($urandom_range(0, 99) < duty);
      if (in_valid[d] && in_ready[d]) begin
        q.push_back(prod(in_a[d], in_b[d]));
        nacc++;
      end
      if (pv) chk("rnd hold", out_p[d], pp);
      if (out_valid[d] && out_ready[d]) begin
        if (q.size() == 0) begin
          chk("rnd extra", q.size(), 1);
        end else begin
          e = q.pop_front();
          chk("rnd product", out_p[d], e);
        end
        nout++;
      end
      pv = out_valid[d] && !out_ready[d];
      pp = out_p[d];
      @(negedge clk);
      cyc++;
    end
    in_valid[d] = 1'b0;
    out_ready[d] = 1'b0;
    chk("rnd count", nout, 1000);
    chk("rnd leftover", q.size(), 0);
  endtask

  initial begin
    logic [3:0]  ex [4];
    logic [3:0]  ey [4];
    logic [15:0] got [$];
    int acc_t [$];
    int nacc;
    int t;
    logic seen;

    ex = '{4'h2, 4'h2, 4'h1, 4'h1};
    ey = '{4'h4, 4'h3, 4'h4, 4'h3};
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      in_valid[d] = 1'b0;
      in_a[d] = 8'h00;
      in_b[d] = 8'h00;
      out_ready[d] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    chk_idle(0, "rst0");
    chk_idle(1, "rst1");
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);
    chk_idle(0, "post rst0");

    // 0x12*0x34 with nibble sequence, then backpressure
    in_a[0] = 8'h12;
    in_b[0] = 8'h34;
    in_valid[0] = 1'b1;
    chk("t1 accept", in_ready[0], 1);
    @(negedge clk);
    in_valid[0] = 1'b0;
    in_a[0] = 8'hAA;
    in_b[0] = 8'hBB;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t1 core_x%0d", k), core_x[0], ex[k]);
      chk($sformatf("t1 core_y%0d", k), core_y[0], ey[k]);
      chk($sformatf("t1 valid%0d", k), out_valid[0], 0);
      @(negedge clk);
    end
    in_valid[0] = 1'b1;
    in_a[0] = 8'h55;
    in_b[0] = 8'h66;
    for (int i = 0; i < 3; i++) begin
      chk("bp valid", out_valid[0], 1);
      chk("bp out_p", out_p[0], 16'h03A8);
      chk("bp in_ready", in_ready[0], 0);
      chk("bp busy", busy[0], 1);
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    chk("bp still valid", out_valid[0], 1);
    chk("bp still 03a8", out_p[0], 16'h03A8);
    @(negedge clk);
    out_ready[0] = 1'b0;
    chk_idle(0, "bp idle");
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | out_valid[0] | busy[0];
    end
    chk("bp no accept", seen, 0);

    xact(0, 8'hFF, 8'hFF, 5, "ff p0");
    xact(1, 8'hFF, 8'hFF, 6, "ff p1");
    xact(1, 8'h12, 8'h34, 6, "12x34 p1");
    xact(1, 8'h00, 8'h00, 6, "0x0 p1");

    // back-to-back: in_valid held high, consumer always ready
    nacc = 0;
    t = 0;
    out_ready[0] = 1'b1;
    in_valid[0] = 1'b1;
    in_a[0] = 8'h0F;
    in_b[0] = 8'hF0;
    while (got.size() < 2 && t < 40) begin
      if (nacc == 1) begin
        in_a[0] = 8'h00;
        in_b[0] = 8'hAB;
      end
      if (nacc >= 2) in_valid[0] = 1'b0;
      if (in_valid[0] && in_ready[0]) begin
        acc_t.push_back(t);
        nacc++;
      end
      if (out_valid[0] && out_ready[0]) got.push_back(out_p[0]);
      @(negedge clk);
      t++;
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b0;
    chk("b2b outputs", got.size(), 2);
    chk("b2b accepts", acc_t.size(), 2);
    if (got.size() == 2 && acc_t.size() == 2) begin
      chk("b2b p0", got[0], 16'h0E10);
      chk("b2b p1", got[1], 16'h0000);
      chk("b2b interval", acc_t[1] - acc_t[0], 6);
    end
    @(negedge clk);

    // reset during step 2
    in_a[0] = 8'h77;
    in_b[0] = 8'h99;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst step2 x", core_x[0], 4'h7);
    chk("rst step2 y", core_y[0], 4'h9);
    rst_n[0] = 1'b0;
    #1;
    chk_idle(0, "abort");
    @(negedge clk);
    rst_n[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | out_valid[0];
    end
    chk("abort no stale", seen, 0);
    xact(0, 8'h03, 8'h05, 5, "after rst");

    rand_run(0, 70);
    rand_run(1, 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
